// File: rtl/cordic_iter_sequencer_if.sv
// Handshake and counter-control bundle between the CORDIC iteration
// sequencer, its up/down iteration counter and the micro-rotation stage.
interface cordic_iter_sequencer_if #(
  parameter int CNT_W = 4
);
  logic             start;
  logic             dir_up;
  logic [CNT_W-1:0] n_iter;
  logic             stall;
  logic             abort;
  logic [CNT_W-1:0] cnt_in;
  logic             load;
  logic             count;
  logic             up_down;
  logic [CNT_W-1:0] N;
  logic             iter_valid;
  logic [CNT_W-1:0] iter_idx;
  logic             busy;
  logic             done;

  // Environment side: issues requests and returns the counter value.
  modport master (
    output start, dir_up, n_iter, stall, abort, cnt_in,
    input  load, count, up_down, N, iter_valid, iter_idx, busy, done
  );

  // Sequencer side.
  modport slave (
    input  start, dir_up, n_iter, stall, abort, cnt_in,
    output load, count, up_down, N, iter_valid, iter_idx, busy, done
  );
endinterface

// File: rtl/cordic_iter_sequencer.sv
// Control FSM for the 4-bit up/down iteration counter of a circular CORDIC.
// Loads the first index, enables counting until the final index is seen on
// cnt_in, then pulses done. Stall freezes progress; abort cancels the run.
module cordic_iter_sequencer #(
  parameter int CNT_W = 4
) (
  input logic                   clk,
  input logic                   sync_reset,
  cordic_iter_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] n_lat;
  logic             dir_lat;
  logic [CNT_W-1:0] final_idx;
  logic             at_final;

  // n_lat is never 0 outside IDLE/DONE, so n_lat-1 cannot wrap while used.
  assign final_idx = dir_lat ? (n_lat - CNT_W'(1)) : '0;
  assign at_final  = (bus.cnt_in == final_idx);

  // State and run-parameter registers; abort outranks stall in LOAD/RUN.
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      state   <= IDLE;
      n_lat   <= '0;
      dir_lat <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            n_lat   <= bus.n_iter;
            dir_lat <= bus.dir_up;
            state   <= (bus.n_iter != '0) ? LOAD : DONE;
          end
        end
        LOAD: state <= bus.abort ? IDLE : RUN;
        RUN: begin
          if (bus.abort) begin
            state <= IDLE;
          end else if (!bus.stall && at_final) begin
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Moore decode from state/latched parameters; count and iter_valid also
  // depend on stall and cnt_in, and the abort cycle suppresses load/count.
  always_comb begin
    bus.load       = 1'b0;
    bus.count      = 1'b0;
    bus.up_down    = 1'b0;
    bus.N          = '0;
    bus.iter_valid = 1'b0;
    bus.iter_idx   = '0;
    bus.busy       = 1'b0;
    bus.done       = 1'b0;
    case (state)
      LOAD: begin
        bus.load    = !bus.abort;
        bus.up_down = dir_lat;
        bus.N       = dir_lat ? '0 : (n_lat - CNT_W'(1));
        bus.busy    = 1'b1;
      end
      RUN: begin
        bus.up_down    = dir_lat;
        bus.busy       = 1'b1;
        bus.iter_idx   = bus.cnt_in;
        bus.iter_valid = !bus.stall;
        bus.count      = !bus.stall && !bus.abort && !at_final;
      end
      DONE:    bus.done = 1'b1;
      default: ;
    endcase
  end

endmodule
